// File: rtl/mvm_pkg.sv
// Shared types and constants for the matrix-vector multiply controller.
package mvm_pkg;

    localparam int IN_W  = 10;
    localparam int OUT_W = 20;

    // Accumulator clamp limits, used only when saturation is compiled in.
    localparam logic [OUT_W-1:0] SAT_MAX = 20'h7FFFF;
    localparam logic [OUT_W-1:0] SAT_MIN = 20'h80000;

    typedef enum logic [1:0] {
        LOAD_M  = 2'd0,
        LOAD_X  = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } mvm_state_e;

endpackage

// File: rtl/mvm_sat_acc.sv
// Registered multiply-accumulate for one matrix row.
// Define MVM_SAT_EN to clamp each accumulate step at the 20-bit signed limits;
// otherwise the sum wraps modulo 2^20.
module mvm_sat_acc
    import mvm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic [OUT_W-1:0] acc
);

    logic [OUT_W-1:0] prod_s;
    logic [OUT_W-1:0] next_s;

    // A 10x10 signed product always fits in 20 bits, so the low 20 bits of the
    // sign-extended multiply are the exact result.
    assign prod_s = {{(OUT_W-IN_W){a[IN_W-1]}}, a} * {{(OUT_W-IN_W){b[IN_W-1]}}, b};

`ifdef MVM_SAT_EN
    logic [OUT_W:0] sum_s;

    assign sum_s = {acc[OUT_W-1], acc} + {prod_s[OUT_W-1], prod_s};

    // Clamp when the two top bits of the widened sum disagree (signed overflow).
    always_comb begin
        next_s = sum_s[OUT_W-1:0];
        if (sum_s[OUT_W] != sum_s[OUT_W-1]) begin
            next_s = sum_s[OUT_W] ? SAT_MIN : SAT_MAX;
        end else begin
            next_s = sum_s[OUT_W-1:0];
        end
    end
`else
    assign next_s = acc + prod_s;
`endif

    // Accumulator register: load starts a row, en adds the next product.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= {OUT_W{1'b0}};
        end else if (load) begin
            acc <= prod_s;
        end else if (en) begin
            acc <= next_s;
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/mvm_mac_ctrl.sv
// Matrix-vector multiply controller: loads an NxN matrix (row-major) and an
// N-vector over a valid/ready stream, then emits y[i] = sum_k M[i][k]*x[k]
// one row at a time. Optional saturation: define MVM_SAT_EN.
module mvm_mac_ctrl
    import mvm_pkg::*;
#(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data
);

    localparam int AW = $clog2(N*N);
    localparam int XW = $clog2(N);

    mvm_state_e      state_r;
    logic [AW-1:0]   cnt_r;
    logic [XW-1:0]   row_r;
    logic [XW-1:0]   col_r;

    logic [IN_W-1:0] m_mem_r [N*N];
    logic [IN_W-1:0] x_mem_r [N];

    logic            accept_s;
    logic [AW-1:0]   m_idx_s;
    logic [IN_W-1:0] op_a_s;
    logic [IN_W-1:0] op_b_s;
    logic            acc_load_s;
    logic            acc_en_s;

    assign accept_s = s_valid && s_ready;
    assign m_idx_s  = AW'(row_r) * AW'(N) + AW'(col_r);
    assign op_a_s   = m_mem_r[m_idx_s];
    assign op_b_s   = x_mem_r[col_r];

    // Operand storage; contents are only meaningful for the job being loaded.
    always_ff @(posedge clk) begin
        if (accept_s && (state_r == LOAD_M)) begin
            m_mem_r[cnt_r] <= s_data;
        end
        if (accept_s && (state_r == LOAD_X)) begin
            x_mem_r[cnt_r[XW-1:0]] <= s_data;
        end
    end

    // Column 0 of each row restarts the accumulator, later columns add to it.
    always_comb begin
        acc_load_s = 1'b0;
        acc_en_s   = 1'b0;
        if (state_r == COMPUTE) begin
            acc_load_s = (col_r == XW'(0));
            acc_en_s   = (col_r != XW'(0));
        end else begin
            acc_load_s = 1'b0;
            acc_en_s   = 1'b0;
        end
    end

    mvm_sat_acc u_acc (
        .clk   (clk),
        .reset (reset),
        .load  (acc_load_s),
        .en    (acc_en_s),
        .a     (op_a_s),
        .b     (op_b_s),
        .acc   (m_data)
    );

    // Job sequencing: load matrix, load vector, then compute/emit each row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= LOAD_M;
            cnt_r   <= AW'(0);
            row_r   <= XW'(0);
            col_r   <= XW'(0);
            s_ready <= 1'b1;
            m_valid <= 1'b0;
        end else begin
            case (state_r)
                LOAD_M: begin
                    if (accept_s) begin
                        if (cnt_r == AW'(N*N-1)) begin
                            cnt_r   <= AW'(0);
                            state_r <= LOAD_X;
                        end else begin
                            cnt_r <= cnt_r + AW'(1);
                        end
                    end
                end
                LOAD_X: begin
                    if (accept_s) begin
                        if (cnt_r == AW'(N-1)) begin
                            cnt_r   <= AW'(0);
                            row_r   <= XW'(0);
                            col_r   <= XW'(0);
                            s_ready <= 1'b0;
                            state_r <= COMPUTE;
                        end else begin
                            cnt_r <= cnt_r + AW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (col_r == XW'(N-1)) begin
                        col_r   <= XW'(0);
                        m_valid <= 1'b1;
                        state_r <= OUTPUT;
                    end else begin
                        col_r <= col_r + XW'(1);
                    end
                end
                OUTPUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (row_r == XW'(N-1)) begin
                            row_r   <= XW'(0);
                            s_ready <= 1'b1;
                            state_r <= LOAD_M;
                        end else begin
                            row_r   <= row_r + XW'(1);
                            state_r <= COMPUTE;
                        end
                    end
                end
                default: begin
                    state_r <= LOAD_M;
                    cnt_r   <= AW'(0);
                    row_r   <= XW'(0);
                    col_r   <= XW'(0);
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
